acc_alu: RTL
============

ACC_ALU -- requirements
Module: acc_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand width in bits (legal 4..32); the accumulator is 2*WIDTH bits.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid  input  1  opcode/operand presented.
REQ-005 The block SHALL have port in_ready  output  1  block can accept; handshake occurs when in_valid && in_ready at a rising edge.
REQ-006 The block SHALL have port opcode  input  4  operation select.
REQ-007 The block SHALL have port a  input  WIDTH  operand A.
REQ-008 The block SHALL have port acc  output  2*WIDTH  accumulator register value.
REQ-009 The block SHALL have port carry  output  1  carry/borrow/shifted-out bit of the last completed op.
REQ-010 The block SHALL have port error  output  1  sticky error flag.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse when an accepted op completes.

Function
REQ-012 The block SHALL decode opcodes as: 0 NOOP, 1 CLR, 5 ADD, 6 SUB, 7 MUL, 9 AND, 10 OR, 11 XOR, 12 NOT, 13 SHL, 14 SHR; all other values are illegal.
REQ-013 ADD/SUB SHALL compute {carry, r} = acc[WIDTH-1:0] +/- a (WIDTH+1 bits); then acc = zero-extended r, and error is set if carry=1 (overflow/borrow).
REQ-014 AND/OR/XOR SHALL operate on acc[WIDTH-1:0] and a; NOT SHALL invert acc[WIDTH-1:0] and ignore a; upper half of acc is zeroed; carry = 0.
REQ-015 SHL/SHR SHALL shift the full 2*WIDTH acc by one, filling with 0; carry = bit shifted out.
REQ-016 NOOP SHALL leave acc, carry and error unchanged; CLR SHALL set acc=0, carry=0 and error=0.
REQ-017 Illegal opcodes SHALL leave acc and carry unchanged and set error.
REQ-018 Single-cycle ops SHALL update acc on the accepting edge; done SHALL be high for the following cycle; in_ready SHALL stay high.
REQ-019 MUL SHALL compute acc = acc[WIDTH-1:0] * a (full 2*WIDTH product, unsigned) iteratively, one bit per cycle.
REQ-020 During MUL, in_ready SHALL be low for exactly WIDTH cycles after the accepting edge; acc SHALL be written on the WIDTH-th edge; done SHALL pulse in the next cycle; carry SHALL be 0; MUL never sets error.
REQ-021 The FSM SHALL have states IDLE and MUL_RUN: IDLE->MUL_RUN on accepted MUL; MUL_RUN->IDLE when the cycle counter reaches WIDTH-1.
REQ-022 The acc output SHALL hold its old value during MUL_RUN; in_valid and opcode SHALL be ignored while in_ready is low.
REQ-023 Operands and opcode SHALL be captured at acceptance; later input changes SHALL not affect an in-flight MUL.
REQ-024 error SHALL be sticky, cleared only by CLR or rst; a set condition and a CLR never coincide, because ops are serial.

Reset
REQ-025 On rst low, the block SHALL immediately set acc=0, carry=0, error=0, done=0, state=IDLE, counter=0, and in_ready=0 while rst is low.
REQ-026 After rst deasserts, in_ready SHALL be 1 from the first rising edge.
REQ-027 Reset during MUL_RUN SHALL abort the multiply with no partial result retained and no done pulse.

Configuration
REQ-028 The macro ACC_ALU_MUL_EN SHALL control the multiplier: when defined, MUL and MUL_RUN are present per REQ-019..021.
REQ-029 When ACC_ALU_MUL_EN is undefined, opcode 7 SHALL be illegal per REQ-017, the multiplier SHALL not be instantiated, and in_ready SHALL be constantly 1 outside reset.

Structure
REQ-030 Package acc_alu_pkg SHALL hold the opcode enum (4-bit), the FSM state enum, and a localparam for the operand width range check.
REQ-031 The iterative shift-add multiplier SHALL be a sub-module acc_alu_mul (start, operands in; busy, product, valid out), instantiated only under ACC_ALU_MUL_EN.

Verification (WIDTH=16)
REQ-032 The bench SHALL check: rst, CLR, then ADD a=1 three times -> acc=3, done pulses each cycle, error=0.
REQ-033 The bench SHALL check: CLR, ADD 0xFFFF, ADD 0x0001 -> acc=0, carry=1, error=1; next NOOP -> error still 1; CLR -> error=0.
REQ-034 The bench SHALL check: acc=0x000F, AND a=0x000B -> acc=0x000B; NOT -> acc=0x0000FFF4; SHL with acc=0x80000000 -> acc=0, carry=1.
REQ-035 The bench SHALL check: acc=0x1234, MUL a=0x0100 -> in_ready low 16 cycles, acc=0x00123400, single done pulse; in_valid toggled during busy is ignored.
REQ-036 The bench SHALL check: opcode 3 -> acc unchanged, error=1; with ACC_ALU_MUL_EN undefined, opcode 7 -> same.
REQ-037 The bench SHALL check: rst asserted at cycle 8 of a MUL -> acc=0, no done, in_ready=1 on the first edge after release.

Source files
------------

// File: rtl/acc_alu_pkg.sv
// Shared definitions for the accumulator ALU: opcode and FSM state encodings,
// plus the legal operand-width range.
package acc_alu_pkg;

  // Legal range for the WIDTH parameter of acc_alu.
  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 32;

  // 4-bit operation codes; any value not listed here is illegal.
  typedef enum logic [3:0] {
    OP_NOOP = 4'd0,
    OP_CLR  = 4'd1,
    OP_ADD  = 4'd5,
    OP_SUB  = 4'd6,
    OP_MUL  = 4'd7,
    OP_AND  = 4'd9,
    OP_OR   = 4'd10,
    OP_XOR  = 4'd11,
    OP_NOT  = 4'd12,
    OP_SHL  = 4'd13,
    OP_SHR  = 4'd14
  } opcode_e;

  // Control FSM: idle (accepting ops) or running an iterative multiply.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } state_e;

  function automatic bit width_legal(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/acc_alu_mul.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
// start captures both operands; the WIDTH following edges each consume one
// bit. valid is high (combinationally) during the last step, and product then
// carries the complete result so the caller can store it on that same edge.
module acc_alu_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic [2*WIDTH-1:0] product,
  output logic               valid
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [2*WIDTH-1:0] partial_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               busy_reg;
  logic [2*WIDTH-1:0] addend;
  logic               last_step;

  // Partial-product term for the current multiplier bit and final-step detect.
  always_comb begin
    addend    = mplier_reg[0] ? mcand_reg : '0;
    last_step = busy_reg && (cnt_reg == LAST_CNT);
  end

  assign busy    = busy_reg;
  assign valid   = last_step;
  assign product = partial_reg + addend;

  // Operand capture on start, then one shift-add step per cycle while busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      partial_reg <= '0;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
    end else if (start) begin
      mcand_reg   <= {{WIDTH{1'b0}}, multiplicand};
      mplier_reg  <= multiplier;
      partial_reg <= '0;
      cnt_reg     <= '0;
      busy_reg    <= 1'b1;
    end else if (busy_reg) begin
      partial_reg <= partial_reg + addend;
      mcand_reg   <= mcand_reg << 1;
      mplier_reg  <= mplier_reg >> 1;
      cnt_reg     <= cnt_reg + 1'b1;
      if (last_step) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/acc_alu.sv
// Accumulator ALU: 2*WIDTH accumulator updated by single-cycle logic/arith
// ops and, when ACC_ALU_MUL_EN is defined, a WIDTH-cycle iterative multiply.
// rst is asynchronous and active-low. Without ACC_ALU_MUL_EN, opcode 7 is
// treated as illegal and in_ready is constantly high outside reset.
module acc_alu
  import acc_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         opcode,
  input  logic [WIDTH-1:0]   a,
  output logic [2*WIDTH-1:0] acc,
  output logic               carry,
  output logic               error,
  output logic               done
);

  if (!width_legal(WIDTH)) begin : g_width_check
    $error("acc_alu: WIDTH must be within 4..32");
  end

  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic               carry_reg, carry_next;
  logic               error_reg, error_next;
  logic               done_reg, done_next;
  logic               alive_reg;
  logic               accept;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;

  assign lo   = acc_reg[WIDTH-1:0];
  assign sum  = {1'b0, lo} + {1'b0, a};
  assign diff = {1'b0, lo} - {1'b0, a};

  assign acc   = acc_reg;
  assign carry = carry_reg;
  assign error = error_reg;
  assign done  = done_reg;

  assign accept = in_valid && in_ready;

  // alive_reg keeps in_ready low while in reset and raises it on the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alive_reg <= 1'b0;
    end else begin
      alive_reg <= 1'b1;
    end
  end

`ifdef ACC_ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_valid;
  logic [2*WIDTH-1:0] mul_product;

  assign mul_start = accept && (opcode == OP_MUL);

  acc_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .rst          (rst),
    .start        (mul_start),
    .multiplicand (lo),
    .multiplier   (a),
    .busy         (mul_busy),
    .product      (mul_product),
    .valid        (mul_valid)
  );

  // FSM state and multiply cycle counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next state: enter MUL_RUN on an accepted MUL, leave after WIDTH cycles.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (mul_start) begin
          state_next = ST_MUL_RUN;
          cnt_next   = '0;
        end
      end
      ST_MUL_RUN: begin
        if (cnt_reg == LAST_CNT) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // FSM outputs: accept new ops only when idle and out of reset.
  always_comb begin
    in_ready = alive_reg && (state_reg == ST_IDLE) && !mul_busy;
  end
`else
  // No multiplier: every op is single-cycle, so ready is simply "out of reset".
  always_comb begin
    in_ready = alive_reg;
  end
`endif

  // Next accumulator/flag values for the accepted op or a finishing multiply.
  always_comb begin
    acc_next   = acc_reg;
    carry_next = carry_reg;
    error_next = error_reg;
    done_next  = 1'b0;
    if (accept) begin
      done_next = 1'b1;
      case (opcode)
        OP_NOOP: ;
        OP_CLR: begin
          acc_next   = '0;
          carry_next = 1'b0;
          error_next = 1'b0;
        end
        OP_ADD: begin
          acc_next   = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
          carry_next = sum[WIDTH];
          if (sum[WIDTH]) error_next = 1'b1;
        end
        OP_SUB: begin
          acc_next   = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
          carry_next = diff[WIDTH];
          if (diff[WIDTH]) error_next = 1'b1;
        end
`ifdef ACC_ALU_MUL_EN
        OP_MUL: begin
          // Result and done come later from the multiplier.
          done_next = 1'b0;
        end
`endif
        OP_AND: begin
          acc_next   = {{WIDTH{1'b0}}, lo & a};
          carry_next = 1'b0;
        end
        OP_OR: begin
          acc_next   = {{WIDTH{1'b0}}, lo | a};
          carry_next = 1'b0;
        end
        OP_XOR: begin
          acc_next   = {{WIDTH{1'b0}}, lo ^ a};
          carry_next = 1'b0;
        end
        OP_NOT: begin
          acc_next   = {{WIDTH{1'b0}}, ~lo};
          carry_next = 1'b0;
        end
        OP_SHL: begin
          acc_next   = {acc_reg[2*WIDTH-2:0], 1'b0};
          carry_next = acc_reg[2*WIDTH-1];
        end
        OP_SHR: begin
          acc_next   = {1'b0, acc_reg[2*WIDTH-1:1]};
          carry_next = acc_reg[0];
        end
        default: begin
          error_next = 1'b1;
        end
      endcase
    end
`ifdef ACC_ALU_MUL_EN
    if (mul_valid) begin
      acc_next   = mul_product;
      carry_next = 1'b0;
      done_next  = 1'b1;
    end
`endif
  end

  // Accumulator, flags and done pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg   <= '0;
      carry_reg <= 1'b0;
      error_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      acc_reg   <= acc_next;
      carry_reg <= carry_next;
      error_reg <= error_next;
      done_reg  <= done_next;
    end
  end

endmodule
